// File: rtl/misao_pkg.sv
// rtl/misao_pkg.sv - shared opcodes, modes, FSM states and CFG field helpers
package misao_pkg;

  localparam logic [3:0] NOP = 4'h0;
  localparam logic [3:0] LDI = 4'h8;
  localparam logic [3:0] XOP = 4'hF;
  localparam logic [3:0] CFG = 4'h1;

  localparam int CFG_MODE_LSB = 0;
  localparam int CFG_MODE_MSB = 1;

  typedef enum logic [1:0] {UL, LK8, LK16} mode_e;

  typedef enum logic [1:0] {ST_FETCH, ST_EXT, ST_CFG_IMM, ST_LDI_IMM} state_e;

  function automatic mode_e cfg_mode(input logic [1:0] mode_bits);
    case (mode_bits)
      2'b01:   return LK8;
      2'b10:   return LK16;
      default: return UL;
    endcase
  endfunction

  function automatic logic [2:0] ldi_len(input mode_e mode);
    case (mode)
      LK8:     return 3'd2;
      LK16:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/misao_fetch_window.sv
// rtl/misao_fetch_window.sv - picks the nibble at PC and the one after it within the same byte
module misao_fetch_window (
  input  logic       i_pc_lsb,
  input  logic [7:0] i_byte,
  output logic [3:0] o_cur_nib,
  output logic [3:0] o_nxt_nib,
  output logic       o_nxt_in_byte
);

  assign o_cur_nib     = i_pc_lsb ? i_byte[7:4] : i_byte[3:0];
  assign o_nxt_nib     = i_byte[7:4];
  assign o_nxt_in_byte = ~i_pc_lsb;

endmodule

// File: rtl/misao_core.sv
// rtl/misao_core.sv - nibble-ISA core: decode FSM, immediate staging and accumulator
module misao_core
  import misao_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_enable_read,
  output logic        mem_enable_write,
  input  logic [7:0]  mem_data_in,
  output logic [14:0] mem_addr,
  output logic        mem_rw,
  output logic [7:0]  mem_data_out,
  output logic [15:0] test_data,
  output logic        test_carry
);

  state_e      r_state, w_state;
  mode_e       r_ldi_mode, w_ldi_mode;
  logic [15:0] r_pc, r_acc, r_stage, w_acc, w_stage;
  logic [7:0]  r_cfg, w_cfg;
  logic [2:0]  r_cnt, w_cnt;
  logic [1:0]  r_idx, w_idx, w_used;
  logic        r_carry, w_done, w_nxt_in_byte;
  logic [3:0]  w_cur_nib, w_nxt_nib, w_nib;

  misao_fetch_window u_fetch_window (
    .i_pc_lsb      (r_pc[0]),
    .i_byte        (mem_data_in),
    .o_cur_nib     (w_cur_nib),
    .o_nxt_nib     (w_nxt_nib),
    .o_nxt_in_byte (w_nxt_in_byte)
  );

  // Up to two nibble steps per cycle; the second only while still inside the byte
  // and the instruction has not ended on the first.
  always_comb begin
    w_state    = r_state;
    w_ldi_mode = r_ldi_mode;
    w_acc      = r_acc;
    w_stage    = r_stage;
    w_cfg      = r_cfg;
    w_cnt      = r_cnt;
    w_idx      = r_idx;
    w_used     = 2'd0;
    w_done     = 1'b0;
    w_nib      = 4'h0;
    for (int k = 0; k < 2; k++) begin
      if (k == 0 || (w_nxt_in_byte && !w_done)) begin
        w_nib  = (k == 0) ? w_cur_nib : w_nxt_nib;
        w_used = w_used + 2'd1;
        case (w_state)
          ST_FETCH: begin
            case (w_nib)
              LDI: begin
                w_ldi_mode = cfg_mode(w_cfg[CFG_MODE_MSB:CFG_MODE_LSB]);
                w_cnt      = ldi_len(w_ldi_mode);
                w_idx      = 2'd0;
                w_state    = ST_LDI_IMM;
              end
              XOP:     w_state = ST_EXT;
              default: w_done  = 1'b1;
            endcase
          end
          ST_EXT: begin
            if (w_nib == CFG) begin
              w_cnt   = 3'd2;
              w_idx   = 2'd0;
              w_state = ST_CFG_IMM;
            end else begin
              w_state = ST_FETCH;
              w_done  = 1'b1;
            end
          end
          ST_CFG_IMM: begin
            w_stage[{w_idx, 2'b00} +: 4] = w_nib;
            if (w_cnt == 3'd1) begin
              w_cfg   = {w_nib, w_stage[3:0]};
              w_state = ST_FETCH;
              w_done  = 1'b1;
            end else begin
              w_cnt = w_cnt - 3'd1;
              w_idx = w_idx + 2'd1;
            end
          end
          default: begin
            w_stage[{w_idx, 2'b00} +: 4] = w_nib;
            if (w_cnt == 3'd1) begin
              case (w_ldi_mode)
                LK8:     w_acc[7:0] = w_stage[7:0];
                LK16:    w_acc      = w_stage;
                default: w_acc[3:0] = w_stage[3:0];
              endcase
              w_state = ST_FETCH;
              w_done  = 1'b1;
            end else begin
              w_cnt = w_cnt - 3'd1;
              w_idx = w_idx + 2'd1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_ldi_mode <= UL;
      r_pc       <= RESET_PC;
      r_acc      <= 16'h0000;
      r_stage    <= 16'h0000;
      r_cfg      <= 8'h00;
      r_cnt      <= 3'd0;
      r_idx      <= 2'd0;
      r_carry    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_ldi_mode <= w_ldi_mode;
      r_pc       <= r_pc + {14'd0, w_used};
      r_acc      <= w_acc;
      r_stage    <= w_stage;
      r_cfg      <= w_cfg;
      r_cnt      <= w_cnt;
      r_idx      <= w_idx;
      r_carry    <= r_carry;
    end
  end

  assign mem_enable_read  = ~rst;
  assign mem_enable_write = 1'b0;
  assign mem_rw           = 1'b0;
  assign mem_data_out     = 8'h00;
  assign mem_addr         = rst ? 15'h0000 : r_pc[15:1];
  assign test_data        = r_acc;
  assign test_carry       = r_carry;

endmodule

// File: tb/tb_misao_core.sv
// tb/tb_misao_core.sv - instruction-level reference model plus directed and random programs
module tb_misao_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:1][0:32767];
  logic [14:0] w_addr  [0:1];
  logic [7:0]  w_din   [0:1];
  logic [7:0]  w_dout  [0:1];
  logic [15:0] w_tdata [0:1];
  logic        w_rd    [0:1];
  logic        w_wr    [0:1];
  logic        w_rw    [0:1];
  logic        w_carry [0:1];

  assign w_din[0] = mem[0][w_addr[0]];
  assign w_din[1] = mem[1][w_addr[1]];

  misao_core u_dut0 (
    .clk(clk), .rst(rst), .mem_enable_read(w_rd[0]), .mem_enable_write(w_wr[0]),
    .mem_data_in(w_din[0]), .mem_addr(w_addr[0]), .mem_rw(w_rw[0]),
    .mem_data_out(w_dout[0]), .test_data(w_tdata[0]), .test_carry(w_carry[0])
  );

  misao_core #(.RESET_PC(16'hFFFE)) u_dut1 (
    .clk(clk), .rst(rst), .mem_enable_read(w_rd[1]), .mem_enable_write(w_wr[1]),
    .mem_data_in(w_din[1]), .mem_addr(w_addr[1]), .mem_rw(w_rw[1]),
    .mem_data_out(w_dout[1]), .test_data(w_tdata[1]), .test_carry(w_carry[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic run_en  = 1'b0;
  logic wr_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: decodes a whole instruction at its first nibble, then
  // retires it nibble-budget by nibble-budget (at most to the end of a byte).
  logic [15:0] m_pc  [0:1];
  logic [15:0] m_acc [0:1];
  logic [15:0] m_val [0:1];
  logic [7:0]  m_cfg [0:1];
  int          m_rem [0:1];
  int          m_kind[0:1];
  int          m_len [0:1];

  function automatic logic [3:0] nib(input int u, input logic [15:0] p);
    logic [7:0] b;
    b = mem[u][p[15:1]];
    return p[0] ? b[7:4] : b[3:0];
  endfunction

  task automatic m_reset(input int u);
    m_pc[u]   = (u == 0) ? 16'h0000 : 16'hFFFE;
    m_acc[u]  = 16'h0000;
    m_cfg[u]  = 8'h00;
    m_val[u]  = 16'h0000;
    m_rem[u]  = 0;
    m_kind[u] = 0;
    m_len[u]  = 0;
  endtask

  task automatic m_step(input int u);
    logic [15:0] p, imm, mask;
    int n;
    if (m_rem[u] == 0) begin
      p = m_pc[u];
      m_kind[u] = 0;
      m_rem[u]  = 1;
      if (nib(u, p) == 4'h8) begin
        m_len[u] = (m_cfg[u][1:0] == 2'b01) ? 2 : (m_cfg[u][1:0] == 2'b10) ? 4 : 1;
        imm = 16'h0000;
        for (int i = 0; i < m_len[u]; i++)
          imm = imm | (16'(nib(u, p + 16'(1 + i))) << (4 * i));
        m_val[u]  = imm;
        m_kind[u] = 1;
        m_rem[u]  = 1 + m_len[u];
      end else if (nib(u, p) == 4'hF) begin
        if (nib(u, p + 16'd1) == 4'h1) begin
          m_kind[u] = 2;
          m_rem[u]  = 4;
          m_val[u]  = {8'h00, nib(u, p + 16'd3), nib(u, p + 16'd2)};
        end else begin
          m_rem[u] = 2;
        end
      end
    end
    n = m_pc[u][0] ? 1 : 2;
    if (n > m_rem[u]) n = m_rem[u];
    m_pc[u]  = m_pc[u] + 16'(n);
    m_rem[u] = m_rem[u] - n;
    if (m_rem[u] == 0) begin
      if (m_kind[u] == 1) begin
        mask     = 16'hFFFF >> (16 - 4 * m_len[u]);
        m_acc[u] = (m_acc[u] & ~mask) | (m_val[u] & mask);
      end else if (m_kind[u] == 2) begin
        m_cfg[u] = m_val[u][7:0];
      end
    end
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) m_reset(u);
      else     m_step(u);
    end
  end

  always @(negedge clk) begin
    if (!rst && run_en) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("acc dut%0d", u), 32'(w_tdata[u]), 32'(m_acc[u]));
        chk($sformatf("addr dut%0d", u), 32'(w_addr[u]), 32'(m_pc[u][15:1]));
        chk($sformatf("bus dut%0d", u),
            32'({w_rd[u], w_wr[u], w_rw[u], w_dout[u], w_carry[u]}), 32'h800);
      end
    end
  end

  always @(posedge clk) if (w_wr[0] || w_wr[1]) wr_seen <= 1'b1;

  task automatic wait_addr(input logic [14:0] a);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (w_addr[0] != a && k < 400);
    chk($sformatf("reach addr %0h", a), 32'(w_addr[0]), 32'(a));
  endtask

  task automatic chk_in_reset(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s rst acc dut%0d", tag, u), 32'(w_tdata[u]), 32'h0);
      chk($sformatf("%s rst addr dut%0d", tag, u), 32'(w_addr[u]), 32'h0);
      chk($sformatf("%s rst bus dut%0d", tag, u),
          32'({w_rd[u], w_wr[u], w_rw[u], w_dout[u], w_carry[u]}), 32'h0);
    end
  endtask

  task automatic clear_mem();
    for (int u = 0; u < 2; u++)
      for (int a = 0; a < 32768; a++) mem[u][a] = 8'h00;
  endtask

  function automatic logic [3:0] rnib();
    case ($urandom_range(0, 7))
      0:       return 4'h0;
      1:       return 4'h8;
      2:       return 4'hF;
      3:       return 4'h1;
      default: return 4'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] rbyte();
    logic [3:0] lo, hi;
    lo = rnib();
    hi = rnib();
    return {hi, lo};
  endfunction

  initial begin
    int n;
    clear_mem();
    mem[0][1]  = 8'h58;
    mem[0][2]  = 8'h1F; mem[0][3]  = 8'h0D; mem[0][4]  = 8'hB8; mem[0][5]  = 8'h0A;
    mem[0][6]  = 8'h1F; mem[0][7]  = 8'h0E; mem[0][8]  = 8'h48; mem[0][9]  = 8'h23;
    mem[0][10] = 8'h01;
    mem[0][11] = 8'h1F; mem[0][12] = 8'h00; mem[0][13] = 8'h98;
    mem[0][14] = 8'h1F; mem[0][15] = 8'h01; mem[0][16] = 8'hD8; mem[0][17] = 8'h0C;
    mem[0][18] = 8'h1F; mem[0][19] = 8'h02; mem[0][20] = 8'h78; mem[0][21] = 8'h56;
    mem[0][22] = 8'h04; mem[0][23] = 8'h77;
    mem[1][32767] = 8'h38; mem[1][0] = 8'h80; mem[1][1] = 8'h06;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_in_reset("init");
    #1 rst = 1'b0;
    run_en = 1'b1;
    #1;
    chk("dut1 start addr", 32'(w_addr[1]), 32'h7FFF);
    chk("dut0 start addr", 32'(w_addr[0]), 32'h0);

    @(negedge clk);
    chk("wrap ldi acc", 32'(w_tdata[1]), 32'h0003);
    chk("wrap addr", 32'(w_addr[1]), 32'h0);
    @(negedge clk);
    chk("ul addr1 first", 32'(w_addr[0]), 32'h1);
    @(negedge clk);
    chk("ul ldi acc", 32'(w_tdata[0]), 32'h0005);
    chk("ul carry", 32'(w_carry[0]), 32'h0);
    chk("straddle addr", 32'(w_addr[1]), 32'h1);
    @(negedge clk);
    chk("straddle ldi acc", 32'(w_tdata[1]), 32'h0006);

    wait_addr(15'd5);
    @(negedge clk);
    chk("lk8 ldi acc", 32'(w_tdata[0]), 32'h00AB);
    wait_addr(15'd10);
    @(negedge clk);
    chk("lk16 ldi acc", 32'(w_tdata[0]), 32'h1234);
    chk("no write strobe", 32'(wr_seen), 32'h0);
    wait_addr(15'd13);
    @(negedge clk);
    chk("partial ul acc", 32'(w_tdata[0]), 32'h1239);
    wait_addr(15'd17);
    @(negedge clk);
    chk("partial lk8 acc", 32'(w_tdata[0]), 32'h12CD);

    wait_addr(15'd21);
    #1 rst = 1'b1;
    #1 chk_in_reset("mid");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    wait_addr(15'd1);
    @(negedge clk);
    chk("post reset ul acc", 32'(w_tdata[0]), 32'h0005);
    wait_addr(15'd22);
    @(negedge clk);
    chk("lk16 rerun acc", 32'(w_tdata[0]), 32'h4567);
    wait_addr(15'd23);
    n = 0;
    while (w_addr[0] == 15'd23 && n < 8) begin
      n++;
      @(negedge clk);
    end
    chk("undef op cycles", 32'(n), 32'd2);

    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      #1 rst = 1'b1;
      clear_mem();
      for (int a = 0; a < 64; a++) begin
        mem[0][a] = rbyte();
        mem[1][a] = rbyte();
      end
      for (int a = 32752; a < 32768; a++) mem[1][a] = rbyte();
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      repeat (300) @(negedge clk);
    end

    chk("no write strobe end", 32'(wr_seen), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
